alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, pipelined integer ALU for the out-of-order back end. Sits between the issue queue/PRF read stage and the writeback/ROB completion bus. It replaces a single-cycle combinational ALU with:
- a two-stage registered datapath
- N configurable bypass channels
- valid/ready backpressure
- flush support
- branch resolution

Parameters:
DATA_W, 32, datapath width; power of two, at least 8
PREG_W, 6, physical register tag width
ROB_W, 5, ROB id width
NUM_BYPASS, 2, number of bypass channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  kill all in-flight ops (mispredict or exception)
in_valid  in  1  issue op valid
in_ready  out  1  op accepted when in_valid && in_ready
in_op  in  5  opcode, encoding under Behaviour
in_id  in  ROB_W  ROB id
in_pc  in  DATA_W  instruction pc
in_src0_tag  in  PREG_W  src0 physical tag
in_src1_tag  in  PREG_W  src1 physical tag
in_src0_data  in  DATA_W  src0 PRF data
in_src1_data  in  DATA_W  src1 PRF data
in_src1_imm  in  1  1: src1 = in_imm, no bypass on src1
in_imm  in  DATA_W  extended immediate, or branch target for conditional/direct branches
in_dst_tag  in  PREG_W  destination tag
in_dst_we  in  1  writes destination
byp_valid  in  NUM_BYPASS  bypass channel valid
byp_tag  in  NUM_BYPASS*PREG_W  bypass tags, channel k at [k*PREG_W +: PREG_W]
byp_data  in  NUM_BYPASS*DATA_W  bypass data
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_id  out  ROB_W  ROB id
out_wen  out  1  PRF write enable
out_dst_tag  out  PREG_W  PRF write tag
out_data  out  DATA_W  result
out_exc_ovf  out  1  integer overflow exception
out_br_taken  out  1  branch taken
out_br_target  out  DATA_W  resolved target

Behaviour:
Opcodes:
- 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 SLT, 5 SLTU
- 6 AND, 7 OR, 8 XOR, 9 NOR, 10 LUI (src1 passed through)
- 11 SLL, 12 SRL, 13 SRA, 14 MOV (src0)
- 15 BEQ, 16 BNE, 17 BGEZ, 18 BGTZ, 19 BLEZ, 20 BLTZ
- 21 J, 22 JR, 23 JAL, 24 JALR, 25 CLZ, 26 CLO
- Other values: result 0, no flags.

Bypass at issue:
- Each source compares its tag against every channel with byp_valid=1.
- Lowest-index matching channel wins; no match uses PRF data.
- Tag 0 never bypasses.

Stage 1 (operand capture, OC):
- Registers resolved operands plus control on accept.
- in_ready = !oc_valid || s2_free, where s2_free = !out_valid || out_ready.

Stage 2:
- Computes the result from OC and registers it when s2_free.
- Accept-to-out_valid latency is 2 cycles with no stall.
- Throughput is 1 op/cycle.
- Stalled OC or S2 contents hold stable; no bypass re-evaluation after capture.

Arithmetic:
- Modulo 2^DATA_W.
- Shift amount = low log2(DATA_W) bits of src1.
- SRA sign-fills.
- SLT is signed, SLTU unsigned; result is 0/1 zero-extended.
- Overflow is set on ADD/SUB only. Then out_exc_ovf=1 and out_wen=0; out_data is don't-care.

Branches:
- Taken rules:
  - BEQ/BNE: src0 ==/!= src1
  - BGEZ: !src0[MSB]
  - BGTZ: positive, nonzero
  - BLEZ: complement of BGTZ
  - BLTZ: src0[MSB]
  - J/JR/JAL/JALR: always taken
- out_br_target = src0 for JR/JALR, else in_imm.
- JAL/JALR write pc+8.
- Non-branch ops: out_br_taken=0, target 0.

CLZ/CLO:
- Leading zero/one count, range 0..DATA_W; all-zero input to CLZ gives DATA_W.

Writeback:
- out_wen = out_valid && dst_we && !out_exc_ovf.

Flush:
- Next cycle oc_valid=0 and out_valid=0.
- in_ready=0 during the flush cycle; an op presented that cycle is dropped.
- flush dominates simultaneous accept or out_ready.

Reset:
- All valid bits 0; all out_* = 0; in_ready=1 the cycle after rst deasserts.
- Reset mid-operation discards contents.

Optional Feature:
ALU_COUNT_EN:
- Defined: CLZ/CLO implemented as above.
- Undefined: opcodes 25/26 return 0, no priority encoder synthesised.

Test Plan:
1. Reset, then ADD src0=0x7FFFFFFF, src1=1 -> 2 cycles later out_valid=1, out_exc_ovf=1, out_wen=0. Repeat with ADDU -> out_data=0x80000000, out_wen=1.
2. Tag conflict: SUB src0_tag=5, PRF=10, byp0 {tag5, 100} and byp1 {tag5, 200}, src1 imm=1 -> out_data=99 (channel 0 wins). Tag 0 with a matching bypass -> PRF value used.
3. Backpressure: 4 back-to-back ORs, out_ready low 3 cycles -> in_ready drops after 2 accepts, no loss or duplication, results in order.
4. Flush with OC and S2 full and in_valid=1 -> next cycle out_valid=0, dropped op never appears.
5. BLEZ src0=0 -> taken, target=in_imm. JALR src0=0x1000, pc=0x400 -> target 0x1000, out_data=0x408.
6. SRA 0x80000000 by 31 -> 0xFFFFFFFF. CLZ 0 -> 32 (ALU_COUNT_EN), 0 without it.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with issue-time bypass,
// valid/ready backpressure, flush and branch resolution.
// Stage 1 (OC) captures resolved operands; stage 2 registers the result.
// Build option: define ALU_COUNT_EN to implement CLZ/CLO (opcodes 25/26);
// without it those opcodes return 0 and no leading-count logic is built.
module alu_pipe #(
    parameter int DATA_W     = 32,
    parameter int PREG_W     = 6,
    parameter int ROB_W      = 5,
    parameter int NUM_BYPASS = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [4:0]                   in_op,
    input  logic [ROB_W-1:0]             in_id,
    input  logic [DATA_W-1:0]            in_pc,
    input  logic [PREG_W-1:0]            in_src0_tag,
    input  logic [PREG_W-1:0]            in_src1_tag,
    input  logic [DATA_W-1:0]            in_src0_data,
    input  logic [DATA_W-1:0]            in_src1_data,
    input  logic                         in_src1_imm,
    input  logic [DATA_W-1:0]            in_imm,
    input  logic [PREG_W-1:0]            in_dst_tag,
    input  logic                         in_dst_we,
    input  logic [NUM_BYPASS-1:0]        byp_valid,
    input  logic [NUM_BYPASS*PREG_W-1:0] byp_tag,
    input  logic [NUM_BYPASS*DATA_W-1:0] byp_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ROB_W-1:0]             out_id,
    output logic                         out_wen,
    output logic [PREG_W-1:0]            out_dst_tag,
    output logic [DATA_W-1:0]            out_data,
    output logic                         out_exc_ovf,
    output logic                         out_br_taken,
    output logic [DATA_W-1:0]            out_br_target
);

    localparam int MSB  = DATA_W - 1;
    localparam int SH_W = $clog2(DATA_W);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADDU = 5'd1,  OP_SUB  = 5'd2,  OP_SUBU = 5'd3,
        OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_AND  = 5'd6,  OP_OR   = 5'd7,
        OP_XOR  = 5'd8,  OP_NOR  = 5'd9,  OP_LUI  = 5'd10, OP_SLL  = 5'd11,
        OP_SRL  = 5'd12, OP_SRA  = 5'd13, OP_MOV  = 5'd14, OP_BEQ  = 5'd15,
        OP_BNE  = 5'd16, OP_BGEZ = 5'd17, OP_BGTZ = 5'd18, OP_BLEZ = 5'd19,
        OP_BLTZ = 5'd20, OP_J    = 5'd21, OP_JR   = 5'd22, OP_JAL  = 5'd23,
        OP_JALR = 5'd24, OP_CLZ  = 5'd25, OP_CLO  = 5'd26
    } op_e;

`ifdef ALU_COUNT_EN
    localparam int CNT_W = $clog2(DATA_W) + 1;

    // Leading-zero count from the MSB down; all-zero input yields DATA_W.
    function automatic logic [CNT_W-1:0] lead_zeros(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] n;
        logic             hit;
        n   = '0;
        hit = 1'b0;
        for (int i = MSB; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 1'b1;
            end
        end
        return n;
    endfunction
`endif

    // OC stage flops
    logic              oc_valid_q,   oc_valid_d;
    op_e               oc_op_q,      oc_op_d;
    logic [ROB_W-1:0]  oc_id_q,      oc_id_d;
    logic [DATA_W-1:0] oc_pc_q,      oc_pc_d;
    logic [DATA_W-1:0] oc_src0_q,    oc_src0_d;
    logic [DATA_W-1:0] oc_src1_q,    oc_src1_d;
    logic [DATA_W-1:0] oc_imm_q,     oc_imm_d;
    logic [PREG_W-1:0] oc_dst_tag_q, oc_dst_tag_d;
    logic              oc_dst_we_q,  oc_dst_we_d;

    // Result stage flops
    logic              out_valid_q,     out_valid_d;
    logic [ROB_W-1:0]  out_id_q,        out_id_d;
    logic [PREG_W-1:0] out_dst_tag_q,   out_dst_tag_d;
    logic              out_dst_we_q,    out_dst_we_d;
    logic [DATA_W-1:0] out_data_q,      out_data_d;
    logic              out_ovf_q,       out_ovf_d;
    logic              out_taken_q,     out_taken_d;
    logic [DATA_W-1:0] out_target_q,    out_target_d;

    logic              s2_free;
    logic              oc_load;
    logic [DATA_W-1:0] src0_res, src1_res;
    logic [DATA_W-1:0] alu_res, alu_target, sum, diff;
    logic              alu_ovf, alu_taken;
    logic [SH_W-1:0]   shamt;

    assign s2_free  = !out_valid_q || out_ready;
    assign oc_load  = !oc_valid_q || s2_free;
    assign in_ready = oc_load && !flush;

    // Resolve issue operands: lowest-index matching bypass channel wins, tag 0 never bypasses.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch can be inferred.
        src0_res = in_src0_data;
        src1_res = in_src1_data;
        for (int k = NUM_BYPASS - 1; k >= 0; k--) begin
            if (byp_valid[k] && (in_src0_tag != '0) &&
                (byp_tag[k*PREG_W +: PREG_W] == in_src0_tag))
                src0_res = byp_data[k*DATA_W +: DATA_W];
            if (byp_valid[k] && (in_src1_tag != '0) &&
                (byp_tag[k*PREG_W +: PREG_W] == in_src1_tag))
                src1_res = byp_data[k*DATA_W +: DATA_W];
        end
        if (in_src1_imm) src1_res = in_imm;
    end

    // Execute the op held in OC: result, overflow and branch resolution.
    always_comb begin
        alu_res    = '0;
        alu_ovf    = 1'b0;
        alu_taken  = 1'b0;
        alu_target = '0;
        sum        = oc_src0_q + oc_src1_q;
        diff       = oc_src0_q - oc_src1_q;
        shamt      = oc_src1_q[SH_W-1:0];
        case (oc_op_q)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (oc_src0_q[MSB] == oc_src1_q[MSB]) && (sum[MSB] != oc_src0_q[MSB]);
            end
            OP_ADDU: alu_res = sum;
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (oc_src0_q[MSB] != oc_src1_q[MSB]) && (diff[MSB] != oc_src0_q[MSB]);
            end
            OP_SUBU: alu_res = diff;
            OP_SLT:  alu_res = DATA_W'($signed(oc_src0_q) < $signed(oc_src1_q));
            OP_SLTU: alu_res = DATA_W'(oc_src0_q < oc_src1_q);
            OP_AND:  alu_res = oc_src0_q & oc_src1_q;
            OP_OR:   alu_res = oc_src0_q | oc_src1_q;
            OP_XOR:  alu_res = oc_src0_q ^ oc_src1_q;
            OP_NOR:  alu_res = ~(oc_src0_q | oc_src1_q);
            OP_LUI:  alu_res = oc_src1_q;
            OP_SLL:  alu_res = oc_src0_q << shamt;
            OP_SRL:  alu_res = oc_src0_q >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(oc_src0_q) >>> shamt);
            OP_MOV:  alu_res = oc_src0_q;
            OP_BEQ: begin
                alu_taken  = (oc_src0_q == oc_src1_q);
                alu_target = oc_imm_q;
            end
            OP_BNE: begin
                alu_taken  = (oc_src0_q != oc_src1_q);
                alu_target = oc_imm_q;
            end
            OP_BGEZ: begin
                alu_taken  = !oc_src0_q[MSB];
                alu_target = oc_imm_q;
            end
            OP_BGTZ: begin
                alu_taken  = !oc_src0_q[MSB] && (|oc_src0_q);
                alu_target = oc_imm_q;
            end
            OP_BLEZ: begin
                alu_taken  = oc_src0_q[MSB] || !(|oc_src0_q);
                alu_target = oc_imm_q;
            end
            OP_BLTZ: begin
                alu_taken  = oc_src0_q[MSB];
                alu_target = oc_imm_q;
            end
            OP_J: begin
                alu_taken  = 1'b1;
                alu_target = oc_imm_q;
            end
            OP_JR: begin
                alu_taken  = 1'b1;
                alu_target = oc_src0_q;
            end
            OP_JAL: begin
                alu_taken  = 1'b1;
                alu_target = oc_imm_q;
                alu_res    = oc_pc_q + DATA_W'(8);
            end
            OP_JALR: begin
                alu_taken  = 1'b1;
                alu_target = oc_src0_q;
                alu_res    = oc_pc_q + DATA_W'(8);
            end
`ifdef ALU_COUNT_EN
            OP_CLZ: alu_res = DATA_W'(lead_zeros(oc_src0_q));
            OP_CLO: alu_res = DATA_W'(lead_zeros(~oc_src0_q));
`endif
            default: ;
        endcase
    end

    // Pipeline advance: OC loads on accept, S2 loads from OC when free; flush empties both.
    always_comb begin
        oc_valid_d    = oc_valid_q;
        oc_op_d       = oc_op_q;
        oc_id_d       = oc_id_q;
        oc_pc_d       = oc_pc_q;
        oc_src0_d     = oc_src0_q;
        oc_src1_d     = oc_src1_q;
        oc_imm_d      = oc_imm_q;
        oc_dst_tag_d  = oc_dst_tag_q;
        oc_dst_we_d   = oc_dst_we_q;
        out_valid_d   = out_valid_q;
        out_id_d      = out_id_q;
        out_dst_tag_d = out_dst_tag_q;
        out_dst_we_d  = out_dst_we_q;
        out_data_d    = out_data_q;
        out_ovf_d     = out_ovf_q;
        out_taken_d   = out_taken_q;
        out_target_d  = out_target_q;

        if (flush) begin
            oc_valid_d = 1'b0;
        end else if (oc_load) begin
            oc_valid_d = in_valid;
            if (in_valid) begin
                oc_op_d      = op_e'(in_op);
                oc_id_d      = in_id;
                oc_pc_d      = in_pc;
                oc_src0_d    = src0_res;
                oc_src1_d    = src1_res;
                oc_imm_d     = in_imm;
                oc_dst_tag_d = in_dst_tag;
                oc_dst_we_d  = in_dst_we;
            end
        end

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (s2_free) begin
            out_valid_d = oc_valid_q;
            if (oc_valid_q) begin
                out_id_d      = oc_id_q;
                out_dst_tag_d = oc_dst_tag_q;
                out_dst_we_d  = oc_dst_we_q;
                out_data_d    = alu_res;
                out_ovf_d     = alu_ovf;
                out_taken_d   = alu_taken;
                out_target_d  = alu_target;
            end
        end
    end

    // State registers with synchronous reset; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples its pre-edge next value.
        if (rst) begin
            oc_valid_q    <= 1'b0;
            oc_op_q       <= OP_ADD;
            oc_id_q       <= '0;
            oc_pc_q       <= '0;
            oc_src0_q     <= '0;
            oc_src1_q     <= '0;
            oc_imm_q      <= '0;
            oc_dst_tag_q  <= '0;
            oc_dst_we_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_id_q      <= '0;
            out_dst_tag_q <= '0;
            out_dst_we_q  <= 1'b0;
            out_data_q    <= '0;
            out_ovf_q     <= 1'b0;
            out_taken_q   <= 1'b0;
            out_target_q  <= '0;
        end else begin
            oc_valid_q    <= oc_valid_d;
            oc_op_q       <= oc_op_d;
            oc_id_q       <= oc_id_d;
            oc_pc_q       <= oc_pc_d;
            oc_src0_q     <= oc_src0_d;
            oc_src1_q     <= oc_src1_d;
            oc_imm_q      <= oc_imm_d;
            oc_dst_tag_q  <= oc_dst_tag_d;
            oc_dst_we_q   <= oc_dst_we_d;
            out_valid_q   <= out_valid_d;
            out_id_q      <= out_id_d;
            out_dst_tag_q <= out_dst_tag_d;
            out_dst_we_q  <= out_dst_we_d;
            out_data_q    <= out_data_d;
            out_ovf_q     <= out_ovf_d;
            out_taken_q   <= out_taken_d;
            out_target_q  <= out_target_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_id        = out_id_q;
    assign out_dst_tag   = out_dst_tag_q;
    assign out_wen       = out_valid_q && out_dst_we_q && !out_ovf_q;
    assign out_data      = out_data_q;
    assign out_exc_ovf   = out_ovf_q;
    assign out_br_taken  = out_taken_q;
    assign out_br_target = out_target_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed-vector bench for alu_pipe with a queue scoreboard.
// The driver pushes the expected response on every accepted op; the monitor
// pops and compares whenever the DUT hands off a result.
module tb_alu_pipe;

    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int ROB_W  = 5;
    localparam int NB     = 2;

    logic                 clk = 1'b0;
    logic                 rst, flush, in_valid, in_ready, in_src1_imm, in_dst_we;
    logic [4:0]           in_op;
    logic [ROB_W-1:0]     in_id;
    logic [DATA_W-1:0]    in_pc, in_src0_data, in_src1_data, in_imm;
    logic [PREG_W-1:0]    in_src0_tag, in_src1_tag, in_dst_tag;
    logic [NB-1:0]        byp_valid;
    logic [NB*PREG_W-1:0] byp_tag;
    logic [NB*DATA_W-1:0] byp_data;
    logic                 out_valid, out_ready, out_wen, out_exc_ovf, out_br_taken;
    logic [ROB_W-1:0]     out_id;
    logic [PREG_W-1:0]    out_dst_tag;
    logic [DATA_W-1:0]    out_data, out_br_target;

    always #5 clk = ~clk;

    alu_pipe #(.DATA_W(DATA_W), .PREG_W(PREG_W), .ROB_W(ROB_W), .NUM_BYPASS(NB)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_id(in_id), .in_pc(in_pc),
        .in_src0_tag(in_src0_tag), .in_src1_tag(in_src1_tag),
        .in_src0_data(in_src0_data), .in_src1_data(in_src1_data),
        .in_src1_imm(in_src1_imm), .in_imm(in_imm),
        .in_dst_tag(in_dst_tag), .in_dst_we(in_dst_we),
        .byp_valid(byp_valid), .byp_tag(byp_tag), .byp_data(byp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_wen(out_wen),
        .out_dst_tag(out_dst_tag), .out_data(out_data), .out_exc_ovf(out_exc_ovf),
        .out_br_taken(out_br_taken), .out_br_target(out_br_target)
    );

    typedef struct {
        logic [4:0]        op;
        logic [PREG_W-1:0] s0_tag;
        logic [DATA_W-1:0] s0;
        logic [PREG_W-1:0] s1_tag;
        logic [DATA_W-1:0] s1;
        logic              s1_imm;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              dst_we;
    } stim_t;

    typedef struct {
        logic [ROB_W-1:0]  id;
        logic [PREG_W-1:0] dst_tag;
        logic [DATA_W-1:0] data;
        logic              check_data;
        logic              wen;
        logic              ovf;
        logic              taken;
        logic [DATA_W-1:0] target;
    } exp_t;

    exp_t             sb[$];
    int               checks   = 0;
    int               failures = 0;
    logic [ROB_W-1:0] next_id  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic stim_t st(input logic [4:0] op, input logic [PREG_W-1:0] s0_tag,
                                 input logic [DATA_W-1:0] s0, input logic [PREG_W-1:0] s1_tag,
                                 input logic [DATA_W-1:0] s1, input logic s1_imm,
                                 input logic [DATA_W-1:0] imm, input logic [DATA_W-1:0] pc,
                                 input logic dst_we);
        stim_t s;
        s.op = op; s.s0_tag = s0_tag; s.s0 = s0; s.s1_tag = s1_tag; s.s1 = s1;
        s.s1_imm = s1_imm; s.imm = imm; s.pc = pc; s.dst_we = dst_we;
        return s;
    endfunction

    function automatic exp_t ex(input logic [DATA_W-1:0] data, input logic check_data,
                                input logic wen, input logic ovf, input logic taken,
                                input logic [DATA_W-1:0] target);
        exp_t e;
        e.id = '0; e.dst_tag = '0; e.data = data; e.check_data = check_data;
        e.wen = wen; e.ovf = ovf; e.taken = taken; e.target = target;
        return e;
    endfunction

    // Drive one op (called at posedge+1) and wait until it is accepted.
    task automatic issue(input stim_t s, input exp_t e);
        bit done;
        done          = 1'b0;
        e.id          = next_id;
        e.dst_tag     = PREG_W'(next_id) + PREG_W'(1);
        in_valid      = 1'b1;
        in_op         = s.op;
        in_id         = e.id;
        in_pc         = s.pc;
        in_src0_tag   = s.s0_tag;
        in_src0_data  = s.s0;
        in_src1_tag   = s.s1_tag;
        in_src1_data  = s.s1;
        in_src1_imm   = s.s1_imm;
        in_imm        = s.imm;
        in_dst_tag    = e.dst_tag;
        in_dst_we     = s.dst_we;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        byp_valid = '0;
        next_id   = next_id + 1'b1;
        check("issue_accepted", 64'(done), 64'(1));
    endtask

    // Wait (bounded) until every expected result has been delivered.
    task automatic drain();
        for (int c = 0; c < 100 && sb.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        check("drained", 64'(sb.size()), 64'(0));
    endtask

    // Monitor: compare each handed-off result against the head of the scoreboard.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && out_valid && out_ready) begin
            check("output_expected", 64'(sb.size() != 0), 64'(1));
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("out_id",        64'(out_id),        64'(e.id));
                check("out_dst_tag",   64'(out_dst_tag),   64'(e.dst_tag));
                check("out_wen",       64'(out_wen),       64'(e.wen));
                check("out_exc_ovf",   64'(out_exc_ovf),   64'(e.ovf));
                check("out_br_taken",  64'(out_br_taken),  64'(e.taken));
                check("out_br_target", 64'(out_br_target), 64'(e.target));
                if (e.check_data) check("out_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    logic [DATA_W-1:0] clz_zero;

    initial begin
`ifdef ALU_COUNT_EN
        clz_zero = 32'd32;
`else
        clz_zero = 32'd0;
`endif
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_id = '0; in_pc = '0; in_src0_tag = '0; in_src1_tag = '0;
        in_src0_data = '0; in_src1_data = '0; in_src1_imm = 1'b0; in_imm = '0;
        in_dst_tag = '0; in_dst_we = 1'b0; byp_valid = '0; byp_tag = '0; byp_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",     64'(in_ready),      64'(1));
        check("rst_out_valid",    64'(out_valid),     64'(0));
        check("rst_out_wen",      64'(out_wen),       64'(0));
        check("rst_out_data",     64'(out_data),      64'(0));
        check("rst_out_br_taken", 64'(out_br_taken),  64'(0));
        check("rst_out_target",   64'(out_br_target), 64'(0));
        @(posedge clk);
        #1;

        // Overflow and modulo arithmetic
        issue(st(5'd0, 0, 32'h7FFF_FFFF, 0, 32'd1, 0, 0, 0, 1), ex(0, 0, 0, 1, 0, 0));
        issue(st(5'd1, 0, 32'h7FFF_FFFF, 0, 32'd1, 0, 0, 0, 1), ex(32'h8000_0000, 1, 1, 0, 0, 0));
        issue(st(5'd2, 0, 32'h8000_0000, 0, 32'd1, 0, 0, 0, 1), ex(0, 0, 0, 1, 0, 0));
        issue(st(5'd3, 0, 32'd0, 0, 32'd1, 0, 0, 0, 1), ex(32'hFFFF_FFFF, 1, 1, 0, 0, 0));

        // Bypass: both channels match tag 5, channel 0 wins
        byp_valid = 2'b11; byp_tag = {6'd5, 6'd5}; byp_data = {32'd200, 32'd100};
        issue(st(5'd2, 6'd5, 32'd10, 0, 0, 1, 32'd1, 0, 1), ex(32'd99, 1, 1, 0, 0, 0));
        // Tag 0 never bypasses even with a matching channel
        byp_valid = 2'b01; byp_tag = {6'd0, 6'd0}; byp_data = {32'd0, 32'd100};
        issue(st(5'd2, 6'd0, 32'd10, 0, 0, 1, 32'd1, 0, 1), ex(32'd9, 1, 1, 0, 0, 0));
        // src1 bypassed from channel 1, src0 from PRF
        byp_valid = 2'b11; byp_tag = {6'd9, 6'd4}; byp_data = {32'd40, 32'd77};
        issue(st(5'd0, 6'd7, 32'd3, 6'd9, 32'd1000, 0, 0, 0, 1), ex(32'd43, 1, 1, 0, 0, 0));

        // Compare, shift, logic, count, invalid opcode
        issue(st(5'd4, 0, 32'hFFFF_FFFF, 0, 32'd1, 0, 0, 0, 1), ex(32'd1, 1, 1, 0, 0, 0));
        issue(st(5'd5, 0, 32'hFFFF_FFFF, 0, 32'd1, 0, 0, 0, 1), ex(32'd0, 1, 1, 0, 0, 0));
        issue(st(5'd13, 0, 32'h8000_0000, 0, 0, 1, 32'd31, 0, 1), ex(32'hFFFF_FFFF, 1, 1, 0, 0, 0));
        issue(st(5'd12, 0, 32'h8000_0000, 0, 0, 1, 32'd33, 0, 1), ex(32'h4000_0000, 1, 1, 0, 0, 0));
        issue(st(5'd9, 0, 32'h0F0F_0000, 0, 32'h0000_00F0, 0, 0, 0, 1), ex(32'hF0F0_FF0F, 1, 1, 0, 0, 0));
        issue(st(5'd25, 0, 32'd0, 0, 0, 0, 0, 0, 1), ex(clz_zero, 1, 1, 0, 0, 0));
        issue(st(5'd27, 0, 32'd5, 0, 32'd6, 0, 0, 0, 1), ex(32'd0, 1, 1, 0, 0, 0));

        // Branches
        issue(st(5'd19, 0, 32'd0, 0, 0, 0, 32'h2000, 32'h100, 0), ex(0, 0, 0, 0, 1, 32'h2000));
        issue(st(5'd18, 0, 32'd0, 0, 0, 0, 32'h2000, 32'h100, 0), ex(0, 0, 0, 0, 0, 32'h2000));
        issue(st(5'd24, 0, 32'h1000, 0, 0, 0, 32'h3000, 32'h400, 1), ex(32'h408, 1, 1, 0, 1, 32'h1000));

        // Backpressure: 2 accepts then in_ready drops while out_ready is low
        drain();
        out_ready = 1'b0;
        issue(st(5'd7, 0, 32'hF0, 0, 32'h0F, 0, 0, 0, 1), ex(32'hFF, 1, 1, 0, 0, 0));
        issue(st(5'd7, 0, 32'h100, 0, 32'h1, 0, 0, 0, 1), ex(32'h101, 1, 1, 0, 0, 0));
        @(negedge clk);
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        @(posedge clk);
        #1 out_ready = 1'b1;
        issue(st(5'd7, 0, 32'h2, 0, 32'h4, 0, 0, 0, 1), ex(32'h6, 1, 1, 0, 0, 0));
        issue(st(5'd7, 0, 32'hA000, 0, 32'h0005, 0, 0, 0, 1), ex(32'hA005, 1, 1, 0, 0, 0));

        // Flush with OC and S2 full and a new op presented
        drain();
        out_ready = 1'b0;
        issue(st(5'd1, 0, 32'd1, 0, 32'd2, 0, 0, 0, 1), ex(32'd3, 1, 1, 0, 0, 0));
        issue(st(5'd1, 0, 32'd3, 0, 32'd4, 0, 0, 0, 1), ex(32'd7, 1, 1, 0, 0, 0));
        in_valid = 1'b1; in_op = 5'd1; in_src0_data = 32'd50; in_src1_data = 32'd60;
        flush = 1'b1;
        @(negedge clk);
        check("flush_s2_full",   64'(out_valid), 64'(1));
        check("flush_in_ready",  64'(in_ready),  64'(0));
        sb.delete();
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_in_ready_after", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Pipeline still works after flush
        issue(st(5'd8, 0, 32'hFF00, 0, 32'h0FF0, 0, 0, 0, 1), ex(32'hF0F0, 1, 1, 0, 0, 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
